// File: rtl/rv32i_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv32i_trace_pkg
// Brief   : Shared state encoding and trace-entry layout for the RV32I
//           retire trace buffer.
// Revision: 1.0 - initial release
// ============================================================================
package rv32i_trace_pkg;

    // Entry storage is laid out for a 32-bit core.
    localparam int unsigned TRACE_XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_POST = 2'd2,
        ST_READ = 2'd3
    } trace_state_t;

    typedef struct packed {
        logic [TRACE_XLEN-1:0] pc;
        logic [31:0]           instr;
        logic                  rd_we;
        logic [4:0]            rd_addr;
        logic [TRACE_XLEN-1:0] rd_data;
    } trace_entry_t;

endpackage : rv32i_trace_pkg
`default_nettype wire

// File: rtl/rv32i_trace_mem.sv
`default_nettype none
// ============================================================================
// Module  : rv32i_trace_mem
// Brief   : DEPTH-entry trace storage, one synchronous write port and one
//           asynchronous read port. Contents are deliberately not reset.
// Revision: 1.0 - initial release
// ============================================================================
module rv32i_trace_mem
    import rv32i_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  trace_entry_t  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output trace_entry_t  o_rdata
);

    trace_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : rv32i_trace_mem
`default_nettype wire

// File: rtl/rv32i_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module  : rv32i_trace_buffer
// Brief   : Circular retire-trace capture with PC-match / software trigger,
//           post-trigger window and oldest-first valid/ready readout.
// Revision: 1.0 - initial release
// ============================================================================
module rv32i_trace_buffer
    import rv32i_trace_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 8,
    parameter int POST_TRIG = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     retire_valid,
    input  logic [XLEN-1:0]          retire_pc,
    input  logic [31:0]              retire_instr,
    input  logic                     retire_rd_we,
    input  logic [4:0]               retire_rd_addr,
    input  logic [XLEN-1:0]          retire_rd_data,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     trig_en,
    input  logic [XLEN-1:0]          trig_pc,
    input  logic                     force_trig,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [31:0]              out_instr,
    output logic                     out_rd_we,
    output logic [4:0]               out_rd_addr,
    output logic [XLEN-1:0]          out_rd_data,
    output logic                     out_last,
    output logic                     done,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     wrapped
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] c_DEPTH      = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_POST_FORCE = CNT_W'(POST_TRIG);
    localparam logic [CNT_W-1:0] c_POST_HIT   = CNT_W'(POST_TRIG - 1);
    localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);

    trace_state_t     r_state;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] r_rd_left;
    logic             r_wrapped;
    logic             r_done;
    logic             r_out_valid;

    logic             w_capturing;
    logic             w_we;
    logic             w_trig;
    logic             w_xfer;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [PTR_W-1:0] w_rd_start;
    trace_entry_t     w_wdata;
    trace_entry_t     w_rd_entry;

    always_comb begin
        w_capturing  = (r_state == ST_PRE) || (r_state == ST_POST);
        w_we         = w_capturing && retire_valid && !abort;
        w_trig       = (r_state == ST_PRE) &&
                       ((retire_valid && trig_en && (retire_pc == trig_pc)) || force_trig);
        w_xfer       = (r_state == ST_READ) && r_out_valid && out_ready;
        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_we);
        w_count_nxt  = (w_we && (r_count != c_DEPTH)) ? (r_count + c_ONE) : r_count;
        // Oldest entry sits count slots behind the post-write pointer.
        w_rd_start   = w_wr_ptr_nxt - w_count_nxt[PTR_W-1:0];

        w_wdata         = '0;
        w_wdata.pc      = retire_pc;
        w_wdata.instr   = retire_instr;
        w_wdata.rd_we   = retire_rd_we;
        w_wdata.rd_addr = retire_rd_addr;
        w_wdata.rd_data = retire_rd_data;
    end

    rv32i_trace_mem #(
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_remaining <= '0;
            r_rd_left   <= '0;
            r_wrapped   <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state     <= ST_IDLE;
                r_count     <= '0;
                r_remaining <= '0;
                r_rd_left   <= '0;
                r_out_valid <= 1'b0;
            end else begin
                if (w_we) begin
                    r_wr_ptr <= w_wr_ptr_nxt;
                    r_count  <= w_count_nxt;
                    if (r_count == c_DEPTH) begin
                        r_wrapped <= 1'b1;
                    end
                end

                unique case (r_state)
                    ST_IDLE: begin
                        if (arm) begin
                            r_state     <= ST_PRE;
                            r_wr_ptr    <= '0;
                            r_count     <= '0;
                            r_remaining <= '0;
                            r_wrapped   <= 1'b0;
                        end
                    end
                    ST_PRE: begin
                        if (w_trig) begin
                            if (retire_valid && (c_POST_HIT == '0)) begin
                                r_state     <= ST_READ;
                                r_done      <= 1'b1;
                                r_out_valid <= 1'b1;
                                r_rd_ptr    <= w_rd_start;
                                r_rd_left   <= w_count_nxt;
                            end else begin
                                r_state     <= ST_POST;
                                r_remaining <= retire_valid ? c_POST_HIT : c_POST_FORCE;
                            end
                        end
                    end
                    ST_POST: begin
                        if (w_we) begin
                            r_remaining <= r_remaining - c_ONE;
                            if (r_remaining == c_ONE) begin
                                r_state     <= ST_READ;
                                r_done      <= 1'b1;
                                r_out_valid <= 1'b1;
                                r_rd_ptr    <= w_rd_start;
                                r_rd_left   <= w_count_nxt;
                            end
                        end
                    end
                    ST_READ: begin
                        if (w_xfer) begin
                            if (r_rd_left == c_ONE) begin
                                r_state     <= ST_IDLE;
                                r_count     <= '0;
                                r_rd_left   <= '0;
                                r_out_valid <= 1'b0;
                            end else begin
                                r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
                                r_rd_left <= r_rd_left - c_ONE;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Fields read zero whenever nothing is being presented.
    assign out_valid   = r_out_valid;
    assign out_last    = r_out_valid && (r_rd_left == c_ONE);
    assign out_pc      = r_out_valid ? w_rd_entry.pc      : '0;
    assign out_instr   = r_out_valid ? w_rd_entry.instr   : '0;
    assign out_rd_we   = r_out_valid ? w_rd_entry.rd_we   : 1'b0;
    assign out_rd_addr = r_out_valid ? w_rd_entry.rd_addr : '0;
    assign out_rd_data = r_out_valid ? w_rd_entry.rd_data : '0;
    assign done        = r_done;
    assign state       = r_state;
    assign count       = r_count;
    assign wrapped     = r_wrapped;

endmodule : rv32i_trace_buffer
`default_nettype wire

// File: tb/tb_rv32i_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv32i_trace_buffer
// Brief   : Self-checking bench: directed capture table, corner sequences and
//           randomized captures against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rv32i_trace_buffer;

    localparam int XLEN      = 32;
    localparam int DEPTH     = 8;
    localparam int POST_TRIG = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            retire_valid = 1'b0;
    logic [XLEN-1:0] retire_pc = '0;
    logic [31:0]     retire_instr = '0;
    logic            retire_rd_we = 1'b0;
    logic [4:0]      retire_rd_addr = '0;
    logic [XLEN-1:0] retire_rd_data = '0;
    logic            arm = 1'b0;
    logic            abort = 1'b0;
    logic            trig_en = 1'b0;
    logic [XLEN-1:0] trig_pc = '0;
    logic            force_trig = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic            out_rd_we;
    logic [4:0]      out_rd_addr;
    logic [XLEN-1:0] out_rd_data;
    logic            out_last;
    logic            done;
    logic [1:0]      state;
    logic [3:0]      count;
    logic            wrapped;

    always #5 clk = ~clk;

    rv32i_trace_buffer #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .POST_TRIG (POST_TRIG)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .retire_valid   (retire_valid),
        .retire_pc      (retire_pc),
        .retire_instr   (retire_instr),
        .retire_rd_we   (retire_rd_we),
        .retire_rd_addr (retire_rd_addr),
        .retire_rd_data (retire_rd_data),
        .arm            (arm),
        .abort          (abort),
        .trig_en        (trig_en),
        .trig_pc        (trig_pc),
        .force_trig     (force_trig),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_rd_we      (out_rd_we),
        .out_rd_addr    (out_rd_addr),
        .out_rd_data    (out_rd_data),
        .out_last       (out_last),
        .done           (done),
        .state          (state),
        .count          (count),
        .wrapped        (wrapped)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int          n_ret;
        int          trig_idx;
        int          force_after;
        bit          stall;
        int          exp_count;
        bit          exp_wrapped;
        logic [31:0] exp_first;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } ref_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_retire(input logic [31:0] pc);
        retire_valid   = 1'b1;
        retire_pc      = pc;
        retire_instr   = $urandom;
        retire_rd_we   = 1'($urandom);
        retire_rd_addr = 5'($urandom);
        retire_rd_data = $urandom;
        step();
        retire_valid   = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    // Readout of PCs first, first+4, ...; optional 5-cycle stall at entry 2.
    task automatic readout(input int n, input logic [31:0] first, input bit stall);
        for (int j = 0; j < n; j++) begin
            if (stall && j == 2) begin
                out_ready    = 1'b0;
                retire_valid = 1'b1;
                retire_pc    = 32'hDEAD_0000;
                arm          = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    step();
                    chk("stall_pc", out_pc, first + 32'(4 * j));
                    chk("stall_valid", out_valid, 1);
                end
                retire_valid = 1'b0;
                arm          = 1'b0;
                chk("stall_count", count, n);
                chk("stall_state", state, 3);
            end
            if (j == 1) chk("done_one_cycle", done, 0);
            chk("rd_valid", out_valid, 1);
            chk("rd_pc", out_pc, first + 32'(4 * j));
            chk("rd_last", out_last, (j == n - 1));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        chk("rd_end_state", state, 0);
        chk("rd_end_count", count, 0);
        chk("rd_end_valid", out_valid, 0);
    endtask

    task automatic run_vec(input vec_t v);
        do_arm();
        chk("arm_state", state, 1);
        trig_en = (v.trig_idx >= 0);
        trig_pc = (v.trig_idx >= 0) ? 32'(4 * v.trig_idx) : 32'hFFFF_FFF0;
        for (int i = 0; i < v.n_ret; i++) begin
            if (i == v.force_after) begin
                force_trig = 1'b1;
                step();
                force_trig = 1'b0;
            end
            do_retire(32'(4 * i));
        end
        chk("cap_state", state, 3);
        chk("cap_done", done, 1);
        chk("cap_count", count, v.exp_count);
        chk("cap_wrapped", wrapped, v.exp_wrapped);
        readout(v.exp_count, v.exp_first, v.stall);
    endtask

    task automatic run_random();
        ref_t        q[$];
        ref_t        e;
        logic [31:0] base;
        int          k, idx, cyc, left, guard;
        bit          use_force, triggered, done_m, wrapped_m, rv, ft;

        do_arm();
        base      = $urandom & 32'h0FFF_FF00;
        k         = $urandom_range(0, 14);
        use_force = ($urandom_range(0, 3) == 0);
        trig_en   = !use_force;
        trig_pc   = base + 32'(4 * k);
        q.delete();
        triggered = 0; done_m = 0; wrapped_m = 0;
        idx = 0; cyc = 0; left = 0;

        while (!done_m && cyc < 200) begin
            rv = ($urandom_range(0, 3) != 0);
            ft = use_force && !triggered && (idx >= k) && ($urandom_range(0, 1) == 1);
            e.pc = base + 32'(4 * idx);
            e.instr = $urandom; e.we = 1'($urandom);
            e.addr = 5'($urandom); e.data = $urandom;
            retire_valid = rv; retire_pc = e.pc; retire_instr = e.instr;
            retire_rd_we = e.we; retire_rd_addr = e.addr; retire_rd_data = e.data;
            force_trig = ft;
            if (rv) begin
                q.push_back(e);
                if (q.size() > DEPTH) begin
                    void'(q.pop_front());
                    wrapped_m = 1;
                end
                idx++;
            end
            if (!triggered) begin
                if ((rv && trig_en && e.pc == trig_pc) || ft) begin
                    triggered = 1;
                    left = rv ? POST_TRIG - 1 : POST_TRIG;
                    if (left == 0) done_m = 1;
                end
            end else if (rv) begin
                left--;
                if (left == 0) done_m = 1;
            end
            step();
            retire_valid = 1'b0;
            force_trig   = 1'b0;
            cyc++;
            if (!done_m) chk("rnd_state", state, triggered ? 2 : 1);
        end
        chk("rnd_timeout", cyc < 200, 1);
        chk("rnd_read", state, 3);
        chk("rnd_done", done, 1);
        chk("rnd_count", count, q.size());
        chk("rnd_wrapped", wrapped, wrapped_m);

        guard = 0;
        while (q.size() > 0 && guard < 200) begin
            chk("rnd_valid", out_valid, 1);
            chk("rnd_pc", out_pc, q[0].pc);
            chk("rnd_instr", out_instr, q[0].instr);
            chk("rnd_we", out_rd_we, q[0].we);
            chk("rnd_addr", out_rd_addr, q[0].addr);
            chk("rnd_data", out_rd_data, q[0].data);
            chk("rnd_last", out_last, (q.size() == 1));
            out_ready = 1'($urandom);
            if (out_ready && out_valid) void'(q.pop_front());
            step();
            out_ready = 1'b0;
            guard++;
        end
        chk("rnd_rd_timeout", guard < 200, 1);
        chk("rnd_idle", state, 0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{n_ret:6,  trig_idx:2,  force_after:-1, stall:1'b0, exp_count:6, exp_wrapped:1'b0, exp_first:32'h00};
        vecs[1] = '{n_ret:20, trig_idx:16, force_after:-1, stall:1'b1, exp_count:8, exp_wrapped:1'b1, exp_first:32'h30};
        vecs[2] = '{n_ret:6,  trig_idx:-1, force_after:2,  stall:1'b0, exp_count:6, exp_wrapped:1'b0, exp_first:32'h00};
        vecs[3] = '{n_ret:4,  trig_idx:0,  force_after:-1, stall:1'b0, exp_count:4, exp_wrapped:1'b0, exp_first:32'h00};
        vecs[4] = '{n_ret:8,  trig_idx:4,  force_after:-1, stall:1'b1, exp_count:8, exp_wrapped:1'b0, exp_first:32'h00};
        vecs[5] = '{n_ret:9,  trig_idx:5,  force_after:-1, stall:1'b0, exp_count:8, exp_wrapped:1'b1, exp_first:32'h04};

        #12;
        chk("rst_state", state, 0);
        chk("rst_count", count, 0);
        chk("rst_wrapped", wrapped, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_pc", out_pc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // IDLE must ignore retires and software triggers.
        force_trig = 1'b1;
        for (int i = 0; i < 3; i++) do_retire(32'(4 * i));
        force_trig = 1'b0;
        chk("idle_ignore_state", state, 0);
        chk("idle_ignore_count", count, 0);

        // Abort beats arm.
        arm = 1'b1; abort = 1'b1;
        step();
        arm = 1'b0; abort = 1'b0;
        chk("abort_over_arm", state, 0);

        for (int v = 0; v < 6; v++) run_vec(vecs[v]);

        // Reset while capturing the post-trigger window.
        do_arm();
        trig_en = 1'b1; trig_pc = 32'h4;
        for (int i = 0; i < 3; i++) do_retire(32'(4 * i));
        chk("midpost_state", state, 2);
        rst_n = 1'b0;
        step();
        chk("midrst_state", state, 0);
        chk("midrst_count", count, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_done", done, 0);
        rst_n = 1'b1;
        step();

        // Abort in POST with three entries, then a clean re-arm.
        do_arm();
        trig_en = 1'b1; trig_pc = 32'h0;
        for (int i = 0; i < 3; i++) do_retire(32'(4 * i));
        chk("pre_abort_state", state, 2);
        chk("pre_abort_count", count, 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_state", state, 0);
        chk("abort_count", count, 0);
        chk("abort_valid", out_valid, 0);
        run_vec(vecs[0]);

        for (int it = 0; it < 30; it++) run_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_rv32i_trace_buffer
`default_nettype wire
